seq_bit_serializer: RTL and testbench
=====================================

Name: seq_bit_serializer

Overview:
- Parallel-in/serial-out stage feeding the serial bit input of the 4-ones sequence detector: one bit per clk.
- Accepts W-bit words over a valid/ready handshake and shifts them out back-to-back with no inter-frame gap.
- Drives IDLE_LEVEL while idle, so runs of ones in the detector are broken between frames.

Parameters:
- W, 8, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit W-1 sent first; 0 = bit 0 sent first.
- IDLE_LEVEL, 0, value driven on x when no frame is active.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- din  input  W  parallel word; sampled only on handshake.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block accepts din this cycle (combinational from state).
- x  output  1  serial bit to the detector, registered.
- x_valid  output  1  x carries a frame bit, registered.
- busy  output  1  frame in progress, registered.
- frame_done  output  1  one-cycle pulse coincident with the last bit of a frame, registered.

Behaviour:
- Reset, sampled at the clk edge with rst=1: state IDLE, shift register 0, bit counter 0, x=IDLE_LEVEL, x_valid=0, busy=0, frame_done=0. din_ready=0 while rst=1.
- A mid-frame reset discards the partial word with no frame_done. The next edge restores reset values.
- States:
  - IDLE: no frame active.
  - SHIFT: data bits are being sent.
  - PARITY: exists only with the optional feature enabled.
- Handshake: a transfer happens at an edge where din_valid=1 and din_ready=1. din_ready=1 in IDLE and in the final bit cycle of a frame; it is 0 otherwise.
- din and din_valid are ignored when no transfer happens.
- Latency: the first bit of an accepted word appears on x in the cycle after the accepting edge.
- Each frame bit is held exactly one cycle with x_valid=1. A frame occupies W consecutive cycles.
- Bit order:
  - MSB_FIRST=1: sends din[W-1] down to din[0].
  - MSB_FIRST=0: sends din[0] up to din[W-1].
- Bit counter runs 0..W-1 and wraps to 0 on a new frame. It never exceeds W-1.
- End of frame: frame_done=1 during the final bit cycle.
  - Transfer in that cycle: the next cycle carries bit 0 of the new frame, with no gap and busy staying 1.
  - No transfer: the next cycle has state IDLE, x=IDLE_LEVEL, x_valid=0, busy=0.
- Transitions:
  - IDLE to SHIFT on a transfer.
  - SHIFT to SHIFT on the last bit with a transfer.
  - SHIFT to IDLE on the last bit without a transfer.
- Simultaneous rst and transfer request: rst wins and the word is not accepted.

Optional Feature:
- Macro SEQ_SER_PARITY_EN.
- Defined:
  - After the W data bits, one extra PARITY cycle sends even parity (XOR of the accepted word) with x_valid=1. Frame length is W+1.
  - frame_done and din_ready move to the parity cycle.
  - Transitions: SHIFT goes to PARITY after the last data bit; PARITY goes to SHIFT or IDLE, by the same rule as above.
- Undefined: no PARITY state, no parity logic, frame length W.

Test Plan:
1. After reset, din=8'hB4 with din_valid for 1 cycle (MSB_FIRST=1): x = 1,0,1,1,0,1,0,0 over 8 cycles with x_valid=1. frame_done is high on the 8th bit only. The next cycle has x=0, x_valid=0, busy=0.
2. din_valid held, din=8'hFF then 8'h0F: 16 contiguous x_valid cycles, x = eight 1s, four 0s, four 1s. din_ready is high only at the two accepting cycles. frame_done pulses twice.
3. MSB_FIRST=0, din=8'h01: x = 1 then seven 0s.
4. din=8'hAA, rst asserted during the 3rd bit cycle: the next cycle has x=0, x_valid=0, busy=0, no frame_done. din_ready=0 while rst=1 and 1 after rst drops.
5. din_valid=0 for 20 cycles while din toggles: x stays IDLE_LEVEL, x_valid=0, no state change.
6. With SEQ_SER_PARITY_EN, din=8'h07: 9 bits 0,0,0,0,0,1,1,1,1. frame_done is high on the 9th bit. A back-to-back second word starts on the cycle after the parity bit.

Source files
------------

// File: rtl/seq_ser_if.sv
// -----------------------------------------------------------------------------
// seq_ser_if -- bundle between a word producer and seq_bit_serializer.
//
// Signals:
//   din        [W-1:0]  parallel word, sampled only on a transfer
//   din_valid           producer has a word to send
//   din_ready           serializer accepts din this cycle
//   x                   serial bit to the sequence detector
//   x_valid             x carries a frame bit
//   busy                frame in progress
//   frame_done          one-cycle pulse on the last bit of a frame
//
// Modports:
//   master : producer / observer side (drives din, din_valid)
//   slave  : serializer side (drives din_ready and the serial outputs)
// -----------------------------------------------------------------------------
interface seq_ser_if #(
  parameter int W = 8
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         x;
  logic         x_valid;
  logic         busy;
  logic         frame_done;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, busy, frame_done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, busy, frame_done
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer -- parallel-in / serial-out stage feeding the 4-ones
// sequence detector, one bit per clk.
//
// Accepts W-bit words over a valid/ready handshake and shifts them out
// back-to-back with no gap between frames. Between frames x sits at
// IDLE_LEVEL so runs of ones seen by the detector are broken.
//
// Parameters:
//   W          word width, 2..32
//   MSB_FIRST  1: din[W-1] first, 0: din[0] first
//   IDLE_LEVEL level driven on x when no frame is active
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active high
//   bus   seq_ser_if.slave (din/din_valid in; din_ready, x, x_valid, busy,
//         frame_done out). din_ready is combinational, the rest registered.
//
// Build option:
//   SEQ_SER_PARITY_EN  when defined, every frame carries one extra cycle with
//                      even parity (XOR of the word); frame_done and din_ready
//                      then move to that parity cycle. Frame length W+1.
// -----------------------------------------------------------------------------
module seq_bit_serializer #(
  parameter int   W          = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  seq_ser_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
`ifndef SEQ_SER_PARITY_EN
  localparam logic [CW-1:0] CNT_PENULT = CW'(W - 2);
`endif

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef SEQ_SER_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  sreg_q,  sreg_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          x_q,     x_d;
  logic          xv_q,    xv_d;
  logic          busy_q,  busy_d;
  logic          fd_q,    fd_d;
`ifdef SEQ_SER_PARITY_EN
  logic          par_q,   par_d;
`endif

  logic          last_beat;
  logic          xfer;
  logic          state_ok;

  // The bit on x is registered in x_q; sreg holds only the bits not yet sent,
  // so the next bit is always at the "outgoing" end of sreg.
  logic          load_bit;
  logic [W-1:0]  load_rem;
  logic          next_bit;
  logic [W-1:0]  next_rem;

  always_comb begin
    if (MSB_FIRST) begin
      load_bit = bus.din[W-1];
      load_rem = {bus.din[W-2:0], 1'b0};
      next_bit = sreg_q[W-1];
      next_rem = {sreg_q[W-2:0], 1'b0};
    end else begin
      load_bit = bus.din[0];
      load_rem = {1'b0, bus.din[W-1:1]};
      next_bit = sreg_q[0];
      next_rem = {1'b0, sreg_q[W-1:1]};
    end
  end

  // The cycle in which a following word may be taken without a gap.
`ifdef SEQ_SER_PARITY_EN
  assign last_beat = (state_q == ST_PARITY);
  assign state_ok  = (state_q == ST_IDLE) || (state_q == ST_SHIFT) ||
                     (state_q == ST_PARITY);
`else
  assign last_beat = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
  assign state_ok  = (state_q == ST_IDLE) || (state_q == ST_SHIFT);
`endif

  // Held low during reset so a word offered alongside rst is never taken.
  assign bus.din_ready = !rst && ((state_q == ST_IDLE) || last_beat);
  assign xfer          = bus.din_valid && bus.din_ready;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    xv_d    = xv_q;
    busy_d  = busy_q;
    fd_d    = fd_q;
`ifdef SEQ_SER_PARITY_EN
    par_d   = par_q;
`endif

    // Mid-frame data bit: advance to the next bit.
    if (state_q == ST_SHIFT && cnt_q != CNT_LAST) begin
      x_d    = next_bit;
      sreg_d = next_rem;
      cnt_d  = cnt_q + CW'(1);
`ifdef SEQ_SER_PARITY_EN
      fd_d   = 1'b0;
`else
      // Registered pulse: raise it on the edge that enters the last bit.
      fd_d   = (cnt_q == CNT_PENULT);
`endif
    end

`ifdef SEQ_SER_PARITY_EN
    // Last data bit: the parity cycle follows and becomes the frame end.
    if (state_q == ST_SHIFT && cnt_q == CNT_LAST) begin
      state_d = ST_PARITY;
      x_d     = par_q;
      sreg_d  = '0;
      cnt_d   = '0;
      fd_d    = 1'b1;
    end
`endif

    // Frame ends with no follow-on word, or the state register is corrupt.
    if ((last_beat && !xfer) || !state_ok) begin
      state_d = ST_IDLE;
      sreg_d  = '0;
      cnt_d   = '0;
      x_d     = IDLE_LEVEL;
      xv_d    = 1'b0;
      busy_d  = 1'b0;
      fd_d    = 1'b0;
    end

    // A transfer only happens in IDLE or on the last beat; either way the new
    // word's first bit goes out on the next cycle.
    if (xfer) begin
      state_d = ST_SHIFT;
      sreg_d  = load_rem;
      cnt_d   = '0;
      x_d     = load_bit;
      xv_d    = 1'b1;
      busy_d  = 1'b1;
      fd_d    = 1'b0;
`ifdef SEQ_SER_PARITY_EN
      par_d   = ^bus.din;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      x_q     <= IDLE_LEVEL;
      xv_q    <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
`ifdef SEQ_SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.x          = x_q;
  assign bus.x_valid    = xv_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_bit_serializer -- self-checking bench for seq_bit_serializer.
// Two instances share clk/rst: dut_m (MSB first) and dut_l (LSB first).
// Expected serial bits are queued when a word is accepted and popped as
// x_valid cycles appear. Build with SEQ_SER_PARITY_EN to cover parity frames.
// -----------------------------------------------------------------------------
module tb_seq_bit_serializer;
  localparam int W = 8;
`ifdef SEQ_SER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_ser_if #(.W(W)) bus_m ();
  seq_ser_if #(.W(W)) bus_l ();

  seq_bit_serializer #(.W(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk (clk), .rst (rst), .bus (bus_m)
  );
  seq_bit_serializer #(.W(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk (clk), .rst (rst), .bus (bus_l)
  );

  int checks = 0;
  int errors = 0;
  bit exp_m[$];
  bit exp_l[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard push for the MSB-first instance.
  task automatic push_m(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) exp_m.push_back(w[W-1-i]);
`ifdef SEQ_SER_PARITY_EN
    exp_m.push_back(^w);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_m.din = '0; bus_m.din_valid = 1'b0;
    bus_l.din = '0; bus_l.din_valid = 1'b0;
    step(); step();
    checks++;
    if ({bus_m.x, bus_m.x_valid, bus_m.busy, bus_m.frame_done, bus_m.din_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got x/xv/busy/fd/rdy=%b want 00000",
               {bus_m.x, bus_m.x_valid, bus_m.busy, bus_m.frame_done, bus_m.din_ready});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus_m.din_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_after: got %b want 1", bus_m.din_ready);
    end
  endtask

  task automatic test_single_frame();
    bit e;
    bus_m.din = 8'hB4; bus_m.din_valid = 1'b1;
    push_m(8'hB4);
    step();
    bus_m.din_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      checks++;
      if (bus_m.x_valid !== 1'b1 || bus_m.busy !== 1'b1) begin
        errors++; $display("FAIL single_xv bit%0d: got xv=%b busy=%b want 1 1", i, bus_m.x_valid, bus_m.busy);
      end
      checks++;
      if (exp_m.size() == 0) begin
        errors++; $display("FAIL single_x bit%0d: got %b want nothing (scoreboard empty)", i, bus_m.x);
      end else begin
        e = exp_m.pop_front();
        if (bus_m.x !== e) begin errors++; $display("FAIL single_x bit%0d: got %b want %b", i, bus_m.x, e); end
      end
      checks++;
      if (bus_m.frame_done !== (i == FL-1)) begin
        errors++; $display("FAIL single_fd bit%0d: got %b want %b", i, bus_m.frame_done, (i == FL-1));
      end
      step();
    end
    checks++;
    if ({bus_m.x, bus_m.x_valid, bus_m.busy, bus_m.frame_done} !== 4'b0) begin
      errors++; $display("FAIL single_after: got x/xv/busy/fd=%b want 0000",
                         {bus_m.x, bus_m.x_valid, bus_m.busy, bus_m.frame_done});
    end
  endtask

  task automatic test_back_to_back();
    bit e;
    bus_m.din = 8'hFF; bus_m.din_valid = 1'b1;
    checks++;
    if (bus_m.din_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready_idle: got %b want 1", bus_m.din_ready);
    end
    push_m(8'hFF);
    step();
    bus_m.din = 8'h0F;
    for (int i = 0; i < 2*FL; i++) begin
      checks++;
      if (bus_m.x_valid !== 1'b1 || bus_m.busy !== 1'b1) begin
        errors++; $display("FAIL b2b_xv cyc%0d: got xv=%b busy=%b want 1 1", i, bus_m.x_valid, bus_m.busy);
      end
      checks++;
      if (exp_m.size() == 0) begin
        errors++; $display("FAIL b2b_x cyc%0d: got %b want nothing (scoreboard empty)", i, bus_m.x);
      end else begin
        e = exp_m.pop_front();
        if (bus_m.x !== e) begin errors++; $display("FAIL b2b_x cyc%0d: got %b want %b", i, bus_m.x, e); end
      end
      checks++;
      if (bus_m.frame_done !== (i == FL-1 || i == 2*FL-1)) begin
        errors++; $display("FAIL b2b_fd cyc%0d: got %b want %b", i, bus_m.frame_done, (i == FL-1 || i == 2*FL-1));
      end
      checks++;
      if (bus_m.din_ready !== (i == FL-1 || i == 2*FL-1)) begin
        errors++; $display("FAIL b2b_ready cyc%0d: got %b want %b", i, bus_m.din_ready, (i == FL-1 || i == 2*FL-1));
      end
      if (i == FL-1) push_m(8'h0F);
      step();
      if (i == FL-1) bus_m.din_valid = 1'b0;
    end
    checks++;
    if (bus_m.x_valid !== 1'b0 || bus_m.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_after: got xv=%b busy=%b want 0 0", bus_m.x_valid, bus_m.busy);
    end
  endtask

  task automatic test_lsb_first();
    bit e;
    logic [W-1:0] w;
    w = 8'h01;
    bus_l.din = w; bus_l.din_valid = 1'b1;
    for (int i = 0; i < W; i++) exp_l.push_back(w[i]);
`ifdef SEQ_SER_PARITY_EN
    exp_l.push_back(^w);
`endif
    step();
    bus_l.din_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      checks++;
      if (bus_l.x_valid !== 1'b1) begin
        errors++; $display("FAIL lsb_xv bit%0d: got %b want 1", i, bus_l.x_valid);
      end else if (exp_l.size() == 0) begin
        errors++; $display("FAIL lsb_x bit%0d: got %b want nothing (scoreboard empty)", i, bus_l.x);
      end else begin
        e = exp_l.pop_front();
        if (bus_l.x !== e) begin errors++; $display("FAIL lsb_x bit%0d: got %b want %b", i, bus_l.x, e); end
      end
      step();
    end
    checks++;
    if (bus_l.x_valid !== 1'b0 || exp_l.size() != 0) begin
      errors++; $display("FAIL lsb_after: got xv=%b left=%0d want 0 0", bus_l.x_valid, exp_l.size());
    end
  endtask

  task automatic test_midframe_reset();
    bit e;
    bus_m.din = 8'hAA; bus_m.din_valid = 1'b1;
    push_m(8'hAA);
    step();
    bus_m.din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      e = exp_m.pop_front();
      if (bus_m.x !== e || bus_m.x_valid !== 1'b1) begin
        errors++; $display("FAIL mid_bits bit%0d: got x=%b xv=%b want %b 1", i, bus_m.x, bus_m.x_valid, e);
      end
      if (i < 2) step();
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus_m.din_ready !== 1'b0) begin
      errors++; $display("FAIL mid_ready_rst: got %b want 0", bus_m.din_ready);
    end
    step();
    checks++;
    if ({bus_m.x, bus_m.x_valid, bus_m.busy, bus_m.frame_done, bus_m.din_ready} !== 5'b0) begin
      errors++; $display("FAIL mid_after_rst: got x/xv/busy/fd/rdy=%b want 00000",
                         {bus_m.x, bus_m.x_valid, bus_m.busy, bus_m.frame_done, bus_m.din_ready});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus_m.din_ready !== 1'b1) begin
      errors++; $display("FAIL mid_ready_release: got %b want 1", bus_m.din_ready);
    end
    exp_m.delete();
    // Word offered together with reset must be dropped.
    step();
    bus_m.din = 8'hFF; bus_m.din_valid = 1'b1; rst = 1'b1;
    step();
    bus_m.din_valid = 1'b0; rst = 1'b0;
    #1;
    checks++;
    if (bus_m.x_valid !== 1'b0 || bus_m.busy !== 1'b0) begin
      errors++; $display("FAIL rst_wins: got xv=%b busy=%b want 0 0", bus_m.x_valid, bus_m.busy);
    end
    step();
    checks++;
    if (bus_m.x_valid !== 1'b0 || bus_m.busy !== 1'b0) begin
      errors++; $display("FAIL rst_wins_next: got xv=%b busy=%b want 0 0", bus_m.x_valid, bus_m.busy);
    end
  endtask

  task automatic test_idle_hold();
    bus_m.din_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus_m.din = W'($urandom);
      step();
      checks++;
      if ({bus_m.x, bus_m.x_valid, bus_m.busy, bus_m.frame_done, bus_m.din_ready} !== 5'b00001) begin
        errors++; $display("FAIL idle_hold cyc%0d: got x/xv/busy/fd/rdy=%b want 00001", i,
                           {bus_m.x, bus_m.x_valid, bus_m.busy, bus_m.frame_done, bus_m.din_ready});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_lsb_first();
    test_midframe_reset();
    test_idle_hold();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
